// File: rtl/fetch_queue_if.sv
// Fetch-stage bus: instruction ROM port, decode-side valid/ready stream,
// redirect request, program start and completion flag.
// The master modport is the fetch stage; the slave modport is its environment.
interface fetch_queue_if #(
    parameter int PC_W   = 6,
    parameter int INST_W = 9
);

    logic              start;
    logic [PC_W-1:0]   rom_addr;
    logic [INST_W-1:0] rom_data;
    logic              out_valid;
    logic [INST_W-1:0] out_inst;
    logic [PC_W-1:0]   out_pc;
    logic              out_ready;
    logic              redirect;
    logic [PC_W-1:0]   redirect_pc;
    logic              done;

    modport master (
        input  start,
        input  rom_data,
        input  out_ready,
        input  redirect,
        input  redirect_pc,
        output rom_addr,
        output out_valid,
        output out_inst,
        output out_pc,
        output done
    );

    modport slave (
        output start,
        output rom_data,
        output out_ready,
        output redirect,
        output redirect_pc,
        input  rom_addr,
        input  out_valid,
        input  out_inst,
        input  out_pc,
        input  done
    );

endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, reads the combinational
// instruction ROM, buffers {inst, pc} pairs in a small FIFO for decode,
// flushes on redirect and raises a sticky done once the HALT word is consumed.
module fetch_queue #(
    parameter int                PC_W      = 6,
    parameter int                INST_W    = 9,
    parameter int                DEPTH     = 2,
    parameter logic [PC_W-1:0]   START_PC  = '0,
    parameter logic [INST_W-1:0] HALT_INST = {INST_W{1'b1}}
) (
    input  logic                 clk,
    input  logic                 reset,
    fetch_queue_if.master        bus
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    logic [PC_W-1:0]   fetch_pc;
    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [PC_W-1:0]   pc_mem   [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;
    logic              done_q;

    logic              pop;
    logic              push;
    logic              flush;

    // Handshake decode: a pop is any accepted head, a flush is a redirect the
    // current state honours, and a push needs room or a simultaneous pop.
    always_comb begin
        pop   = (count != '0) && bus.out_ready;
        flush = bus.redirect && ((state == FETCH) || (state == DRAIN));
        push  = (state == FETCH) && !bus.redirect && ((count < FULL_CNT) || pop);
    end

    assign bus.rom_addr  = fetch_pc;
    assign bus.out_valid = (count != '0);
    assign bus.out_inst  = inst_mem[head];
    assign bus.out_pc    = pc_mem[head];
    assign bus.done      = done_q;

    // Fetch FSM and queue storage; redirect overrides push and pop, the HALT
    // word parks the PC and waits in DRAIN until decode consumes it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            fetch_pc <= START_PC;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            done_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                inst_mem[i] <= '0;
                pc_mem[i]   <= '0;
            end
        end else if (flush) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            fetch_pc <= bus.redirect_pc;
            state    <= FETCH;
        end else begin
            if (push) begin
                inst_mem[tail] <= bus.rom_data;
                pc_mem[tail]   <= fetch_pc;
                tail           <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + ONE_CNT;
            end else if (!push && pop) begin
                count <= count - ONE_CNT;
            end
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state    <= FETCH;
                        fetch_pc <= START_PC;
                    end
                end
                FETCH: begin
                    if (push) begin
                        if (bus.rom_data == HALT_INST) begin
                            state <= DRAIN;
                        end else begin
                            fetch_pc <= fetch_pc + PC_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (pop && (count == ONE_CNT)) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus randomized episodes. The
// reference model is the instruction stream decode should see: consecutive
// ROM words from the start or redirect target, up to and including HALT.
module tb_fetch_queue;

    localparam int         PC_W     = 6;
    localparam int         INST_W   = 9;
    localparam logic [5:0] START_PC = 6'd0;
    localparam logic [8:0] HALT     = 9'h1FF;

    typedef struct packed {
        logic [8:0] inst;
        logic [5:0] pc;
    } entry_t;

    logic clk = 1'b0;
    logic reset = 1'b0;

    logic [8:0] rom [64];
    entry_t     exp_q [$];
    bit         exp_done;
    bit         model_active;
    int         compared;
    int         mismatched;

    fetch_queue_if #(.PC_W(PC_W), .INST_W(INST_W)) bus ();

    fetch_queue #(
        .PC_W     (PC_W),
        .INST_W   (INST_W),
        .DEPTH    (2),
        .START_PC (START_PC),
        .HALT_INST(HALT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.master)
    );

    // Clock generation
    always #5 clk = ~clk;

    // Combinational instruction ROM seen by the fetch stage
    assign bus.rom_data = rom[bus.rom_addr];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected stream from a PC: successive words until HALT inclusive
    task automatic fillStream(input logic [5:0] from_pc);
        logic [5:0] p;
        entry_t     e;
        p = from_pc;
        exp_q.delete();
        for (int n = 0; n < 400; n++) begin
            e.inst = rom[p];
            e.pc   = p;
            exp_q.push_back(e);
            if (rom[p] == HALT) break;
            p = p + 6'd1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of inputs, then update the stream model for any start
    // or redirect the design will have sampled at that edge
    task automatic applyStimulus(input bit st, input bit rdy, input bit rd, input logic [5:0] rpc);
        bit was_active;
        was_active = model_active && !exp_done;
        bus.start       = st;
        bus.out_ready   = rdy;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        if (st && !model_active && !exp_done) begin
            fillStream(START_PC);
            model_active = 1'b1;
        end
        tick();
        if (rd && was_active) begin
            fillStream(rpc);
        end
        bus.start    = 1'b0;
        bus.redirect = 1'b0;
    endtask

    task automatic doReset(input int cycles);
        reset        = 1'b0;
        bus.start    = 1'b0;
        bus.redirect = 1'b0;
        exp_q.delete();
        exp_done     = 1'b0;
        model_active = 1'b0;
        repeat (cycles) tick();
        reset = 1'b1;
    endtask

    task automatic loadCountingRom();
        for (int k = 0; k < 64; k++) rom[k] = 9'(k + 1);
    endtask

    // Monitor: every accepted head must be the next word of the model stream
    always @(negedge clk) begin
        entry_t e;
        if (reset) begin
            checkOutput("done", 32'(bus.done), 32'(exp_done));
            if (exp_done) begin
                checkOutput("valid_after_done", 32'(bus.out_valid), 32'd0);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("spurious_valid", 32'(bus.out_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("stream_inst", 32'(bus.out_inst), 32'(e.inst));
                    checkOutput("stream_pc", 32'(bus.out_pc), 32'(e.pc));
                    if (e.inst == HALT) exp_done = 1'b1;
                end
            end
        end
    end

    initial begin
        bus.start       = 1'b0;
        bus.out_ready   = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        compared        = 0;
        mismatched      = 0;
        loadCountingRom();

        // Reset state and start latency with a streaming consumer
        doReset(2);
        checkOutput("reset_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset_done", 32'(bus.done), 32'd0);
        checkOutput("reset_inst", 32'(bus.out_inst), 32'd0);
        checkOutput("reset_pc", 32'(bus.out_pc), 32'd0);
        checkOutput("reset_rom_addr", 32'(bus.rom_addr), 32'(START_PC));
        applyStimulus(1, 1, 0, 0);
        checkOutput("start_rom_addr", 32'(bus.rom_addr), 32'(START_PC));
        checkOutput("start_valid_low", 32'(bus.out_valid), 32'd0);
        applyStimulus(0, 1, 0, 0);
        checkOutput("first_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("first_inst", 32'(bus.out_inst), 32'd1);
        checkOutput("first_pc", 32'(bus.out_pc), 32'd0);
        repeat (6) begin
            applyStimulus(0, 1, 0, 0);
            checkOutput("throughput_valid", 32'(bus.out_valid), 32'd1);
        end

        // Backpressure fills the queue and stalls the fetch PC
        doReset(1);
        applyStimulus(1, 0, 0, 0);
        repeat (5) applyStimulus(0, 0, 0, 0);
        checkOutput("stall_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("stall_inst", 32'(bus.out_inst), 32'd1);
        checkOutput("stall_pc", 32'(bus.out_pc), 32'd0);
        checkOutput("stall_rom_addr", 32'(bus.rom_addr), 32'd2);
        repeat (4) begin
            applyStimulus(0, 1, 0, 0);
            checkOutput("resume_valid", 32'(bus.out_valid), 32'd1);
        end

        // Redirect while the queue is full
        repeat (3) applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 1, 6'd40);
        checkOutput("redir_valid_low", 32'(bus.out_valid), 32'd0);
        checkOutput("redir_rom_addr", 32'(bus.rom_addr), 32'd40);
        applyStimulus(0, 1, 0, 0);
        checkOutput("redir_target_pc", 32'(bus.out_pc), 32'd40);
        repeat (3) applyStimulus(0, 1, 0, 0);

        // PC wrap from 63 to 0
        doReset(1);
        rom[63] = 9'h005;
        rom[0]  = 9'h006;
        applyStimulus(1, 1, 0, 0);
        applyStimulus(0, 1, 1, 6'd63);
        checkOutput("wrap_rom_addr", 32'(bus.rom_addr), 32'd63);
        applyStimulus(0, 1, 0, 0);
        checkOutput("wrap_pc63", 32'(bus.out_pc), 32'd63);
        checkOutput("wrap_inst63", 32'(bus.out_inst), 32'h005);
        applyStimulus(0, 1, 0, 0);
        checkOutput("wrap_pc0", 32'(bus.out_pc), 32'd0);
        checkOutput("wrap_inst0", 32'(bus.out_inst), 32'h006);
        repeat (2) applyStimulus(0, 1, 0, 0);

        // HALT at address 3 ends the program; done is sticky
        doReset(1);
        loadCountingRom();
        rom[3] = HALT;
        applyStimulus(1, 1, 0, 0);
        repeat (8) applyStimulus(0, 1, 0, 0);
        checkOutput("halt_done", 32'(bus.done), 32'd1);
        checkOutput("halt_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("halt_rom_addr", 32'(bus.rom_addr), 32'd3);
        applyStimulus(1, 1, 1, 6'd10);
        repeat (2) applyStimulus(0, 1, 0, 0);
        checkOutput("halt_sticky_done", 32'(bus.done), 32'd1);
        checkOutput("halt_sticky_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("halt_sticky_addr", 32'(bus.rom_addr), 32'd3);

        // Speculative HALT discarded by a redirect, then a mid-stream reset
        doReset(1);
        checkOutput("reset_done_clear", 32'(bus.done), 32'd0);
        rom[3] = 9'd4;
        rom[1] = HALT;
        applyStimulus(1, 0, 0, 0);
        repeat (4) applyStimulus(0, 0, 0, 0);
        checkOutput("drain_rom_addr", 32'(bus.rom_addr), 32'd1);
        checkOutput("drain_done", 32'(bus.done), 32'd0);
        applyStimulus(0, 0, 1, 6'd10);
        checkOutput("drain_redir_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("drain_redir_addr", 32'(bus.rom_addr), 32'd10);
        repeat (6) applyStimulus(0, 1, 0, 0);
        checkOutput("drain_no_done", 32'(bus.done), 32'd0);
        checkOutput("drain_resumed", 32'(bus.out_valid), 32'd1);
        doReset(1);
        checkOutput("midreset_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("midreset_done", 32'(bus.done), 32'd0);
        checkOutput("midreset_rom_addr", 32'(bus.rom_addr), 32'(START_PC));

        // Randomized episodes: random ROM with sparse HALTs, random
        // backpressure, redirects and ignored start pulses
        for (int ep = 0; ep < 8; ep++) begin
            for (int k = 0; k < 64; k++) begin
                rom[k] = ($urandom_range(0, 99) < 4) ? HALT : 9'($urandom_range(0, 510));
            end
            doReset(2);
            applyStimulus(1, 1, 0, 0);
            for (int c = 0; c < 250; c++) begin
                bit         st;
                bit         rdy;
                bit         rd;
                logic [5:0] rpc;
                rd  = ($urandom_range(0, 99) < 5);
                rpc = 6'($urandom);
                st  = ($urandom_range(0, 99) < 3);
                rdy = ($urandom_range(0, 3) != 0);
                if (rd && (exp_q.size() > 0) && (exp_q[0].inst == HALT)) rdy = 1'b0;
                applyStimulus(st, rdy, rd, rpc);
            end
        end

        bus.out_ready = 1'b0;
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
